// File: rtl/mem_stage_dm_access.sv
// mem_stage_dm_access
// Memory-stage data-memory access controller for the 5-stage MIPS pipeline.
// Turns the load/store control of the instruction in MEM into a
// request/acknowledge transaction on a variable-latency data-memory port.
// The pipeline is stalled while the access is outstanding. The load result
// is registered and presented to the MEM/WB register.
//
// Optional feature macro: DM_TIMEOUT_EN
//   defined   -> ACCESS gives up after TIMEOUT_CYCLES cycles without ack,
//                pulses MEM_bus_error and returns 0xDEADBEEF on loads.
//   undefined -> ACCESS waits indefinitely; MEM_bus_error tied to 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no access outstanding; detect a new load/store in MEM
// ACCESS | dmem_req high, waiting for dmem_ack (pipeline stalled)
// DONE   | access finished, pipeline advances, MEM/WB captures result
//
// Ports:
//   clock, reset             single clock, synchronous active-high reset
//   MEM_valid                instruction in MEM is not a bubble
//   MEM_dm_read_enable       load
//   MEM_dm_write_enable      store (wins when both enables are set)
//   MEM_alu_result[31:0]     effective byte address
//   MEM_store_data[31:0]     store data
//   dmem_req/we/addr/wdata   registered data-memory request
//   dmem_ack, dmem_rdata     memory acknowledge and read data (same cycle)
//   MEM_dm_read_data[31:0]   registered load result
//   MEM_stall                hold the upstream pipeline
//   MEM_misaligned           pulse on an access with address[1:0] != 0
//   MEM_bus_error            pulse when an access times out
module mem_stage_dm_access #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        MEM_valid,
   input  logic        MEM_dm_read_enable,
   input  logic        MEM_dm_write_enable,
   input  logic [31:0] MEM_alu_result,
   input  logic [31:0] MEM_store_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [29:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] MEM_dm_read_data,
   output logic        MEM_stall,
   output logic        MEM_misaligned,
   output logic        MEM_bus_error
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic access;
   logic aligned;
   logic timeout;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   assign access  = MEM_valid & (MEM_dm_read_enable | MEM_dm_write_enable);
   assign aligned = (MEM_alu_result[1:0] == 2'b00);

`ifdef DM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 4) ? 4 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] timeout_cnt;

   // Counter sits at 0 outside ACCESS, so it is already clear on entry.
   always_ff @(posedge clock) begin
      if (reset) begin
         timeout_cnt <= '0;
      end else if (state == ACCESS) begin
         timeout_cnt <= timeout_cnt + 1'b1;
      end else begin
         timeout_cnt <= '0;
      end
   end

   // Fires in the TIMEOUT_CYCLES-th ACCESS cycle if that cycle brings no ack.
   assign timeout = (state == ACCESS) && !dmem_ack && (timeout_cnt == CNT_LAST);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      MEM_stall      = 1'b0;
      MEM_misaligned = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               if (aligned) begin
                  MEM_stall = 1'b1;
                  state_nxt = ACCESS;
               end else begin
                  MEM_misaligned = 1'b1;
               end
            end
         end
         ACCESS: begin
            MEM_stall = 1'b1;
            if (dmem_ack || timeout) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request fields are loaded only when leaving IDLE so they stay stable
   // for the whole ACCESS phase; req alone drops when the access ends.
   always_ff @(posedge clock) begin
      if (reset) begin
         dmem_req         <= 1'b0;
         dmem_we          <= 1'b0;
         dmem_addr        <= '0;
         dmem_wdata       <= '0;
         MEM_dm_read_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (access) begin
                  if (aligned) begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= MEM_dm_write_enable;
                     dmem_addr  <= MEM_alu_result[31:2];
                     dmem_wdata <= MEM_store_data;
                  end else begin
                     MEM_dm_read_data <= '0;
                  end
               end
            end
            ACCESS: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (!dmem_we) begin
                     MEM_dm_read_data <= dmem_rdata;
                  end
               end else if (timeout) begin
                  dmem_req <= 1'b0;
                  if (!dmem_we) begin
                     MEM_dm_read_data <= 32'hDEAD_BEEF;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef DM_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         MEM_bus_error <= 1'b0;
      end else begin
         MEM_bus_error <= timeout;
      end
   end
`else
   assign MEM_bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_dm_access.sv
// Directed testbench for mem_stage_dm_access. Inputs change 1 time unit after
// the rising edge; outputs are sampled 3 time units after the rising edge.
module tb_mem_stage_dm_access;

   logic        clock = 1'b0;
   logic        reset;
   logic        MEM_valid;
   logic        MEM_dm_read_enable;
   logic        MEM_dm_write_enable;
   logic [31:0] MEM_alu_result;
   logic [31:0] MEM_store_data;
   logic        dmem_req;
   logic        dmem_we;
   logic [29:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [31:0] MEM_dm_read_data;
   logic        MEM_stall;
   logic        MEM_misaligned;
   logic        MEM_bus_error;

   int checks = 0;
   int passed = 0;

   always #5 clock = ~clock;

   mem_stage_dm_access #(.TIMEOUT_CYCLES(15)) dut (
      .clock               (clock),
      .reset               (reset),
      .MEM_valid           (MEM_valid),
      .MEM_dm_read_enable  (MEM_dm_read_enable),
      .MEM_dm_write_enable (MEM_dm_write_enable),
      .MEM_alu_result      (MEM_alu_result),
      .MEM_store_data      (MEM_store_data),
      .dmem_req            (dmem_req),
      .dmem_we             (dmem_we),
      .dmem_addr           (dmem_addr),
      .dmem_wdata          (dmem_wdata),
      .dmem_ack            (dmem_ack),
      .dmem_rdata          (dmem_rdata),
      .MEM_dm_read_data    (MEM_dm_read_data),
      .MEM_stall           (MEM_stall),
      .MEM_misaligned      (MEM_misaligned),
      .MEM_bus_error       (MEM_bus_error)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      MEM_valid           = 1'b0;
      MEM_dm_read_enable  = 1'b0;
      MEM_dm_write_enable = 1'b0;
      MEM_alu_result      = 32'h0;
      MEM_store_data      = 32'h0;
      dmem_ack            = 1'b0;
      dmem_rdata          = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hFFFF_FFFF;
      tick();
      tick();
      reset    = 1'b0;
      dmem_ack = 1'b0;
      #2;
      checks++; if (dmem_req !== 1'b0) $display("FAIL reset_req got %b want 0", dmem_req); else passed++;
      checks++; if (dmem_we !== 1'b0) $display("FAIL reset_we got %b want 0", dmem_we); else passed++;
      checks++; if (dmem_addr !== 30'h0) $display("FAIL reset_addr got %h want 0", dmem_addr); else passed++;
      checks++; if (dmem_wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", dmem_wdata); else passed++;
      checks++; if (MEM_dm_read_data !== 32'h0) $display("FAIL reset_rdata got %h want 0", MEM_dm_read_data); else passed++;
      checks++; if (MEM_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", MEM_stall); else passed++;
      checks++; if (MEM_misaligned !== 1'b0) $display("FAIL reset_misaligned got %b want 0", MEM_misaligned); else passed++;
      checks++; if (MEM_bus_error !== 1'b0) $display("FAIL reset_bus_error got %b want 0", MEM_bus_error); else passed++;
      tick();
   endtask

   task automatic test_load();
      MEM_valid          = 1'b1;
      MEM_dm_read_enable = 1'b1;
      MEM_alu_result     = 32'h0000_0010;
      #2;
      checks++; if (MEM_stall !== 1'b1) $display("FAIL load_detect_stall got %b want 1", MEM_stall); else passed++;
      checks++; if (dmem_req !== 1'b0) $display("FAIL load_detect_req got %b want 0", dmem_req); else passed++;
      tick();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1234_5678;
      #2;
      checks++; if (dmem_req !== 1'b1) $display("FAIL load_access_req got %b want 1", dmem_req); else passed++;
      checks++; if (dmem_addr !== 30'h4) $display("FAIL load_addr got %h want 4", dmem_addr); else passed++;
      checks++; if (dmem_we !== 1'b0) $display("FAIL load_we got %b want 0", dmem_we); else passed++;
      checks++; if (MEM_stall !== 1'b1) $display("FAIL load_access_stall got %b want 1", MEM_stall); else passed++;
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      #2;
      checks++; if (MEM_stall !== 1'b0) $display("FAIL load_done_stall got %b want 0", MEM_stall); else passed++;
      checks++; if (dmem_req !== 1'b0) $display("FAIL load_done_req got %b want 0", dmem_req); else passed++;
      checks++; if (MEM_dm_read_data !== 32'h1234_5678) $display("FAIL load_data got %h want 12345678", MEM_dm_read_data); else passed++;
      tick();
      idle_inputs();
      #2;
      checks++; if (MEM_stall !== 1'b0) $display("FAIL load_after_stall got %b want 0", MEM_stall); else passed++;
      tick();
   endtask

   task automatic test_store();
      int stall_cnt = 0;
      MEM_valid           = 1'b1;
      MEM_dm_write_enable = 1'b1;
      MEM_alu_result      = 32'h0000_0020;
      MEM_store_data      = 32'hCAFE_F00D;
      #2;
      if (MEM_stall === 1'b1) stall_cnt++;
      tick();
      for (int k = 1; k <= 4; k++) begin
         dmem_ack   = (k == 4);
         dmem_rdata = 32'h5A5A_5A5A;
         #2;
         if (MEM_stall === 1'b1) stall_cnt++;
         checks++; if (dmem_req !== 1'b1) $display("FAIL store_req cycle %0d got %b want 1", k, dmem_req); else passed++;
         checks++; if (dmem_we !== 1'b1) $display("FAIL store_we cycle %0d got %b want 1", k, dmem_we); else passed++;
         checks++; if (dmem_addr !== 30'h8) $display("FAIL store_addr cycle %0d got %h want 8", k, dmem_addr); else passed++;
         checks++; if (dmem_wdata !== 32'hCAFE_F00D) $display("FAIL store_wdata cycle %0d got %h want cafef00d", k, dmem_wdata); else passed++;
         tick();
      end
      dmem_ack = 1'b0;
      #2;
      if (MEM_stall === 1'b1) stall_cnt++;
      checks++; if (MEM_stall !== 1'b0) $display("FAIL store_done_stall got %b want 0", MEM_stall); else passed++;
      checks++; if (stall_cnt != 5) $display("FAIL store_stall_count got %0d want 5", stall_cnt); else passed++;
      checks++; if (MEM_dm_read_data !== 32'h1234_5678) $display("FAIL store_read_data got %h want 12345678", MEM_dm_read_data); else passed++;
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_misaligned();
      MEM_valid          = 1'b1;
      MEM_dm_read_enable = 1'b1;
      MEM_alu_result     = 32'h0000_0013;
      #2;
      checks++; if (MEM_misaligned !== 1'b1) $display("FAIL misaligned_pulse got %b want 1", MEM_misaligned); else passed++;
      checks++; if (MEM_stall !== 1'b0) $display("FAIL misaligned_stall got %b want 0", MEM_stall); else passed++;
      checks++; if (dmem_req !== 1'b0) $display("FAIL misaligned_req got %b want 0", dmem_req); else passed++;
      tick();
      idle_inputs();
      #2;
      checks++; if (MEM_misaligned !== 1'b0) $display("FAIL misaligned_after got %b want 0", MEM_misaligned); else passed++;
      checks++; if (dmem_req !== 1'b0) $display("FAIL misaligned_req_after got %b want 0", dmem_req); else passed++;
      checks++; if (MEM_dm_read_data !== 32'h0) $display("FAIL misaligned_data got %h want 0", MEM_dm_read_data); else passed++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic exp_stall [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic exp_req   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      MEM_valid          = 1'b1;
      MEM_dm_read_enable = 1'b1;
      for (int c = 0; c < 6; c++) begin
         MEM_alu_result = (c < 3) ? 32'h0000_0008 : 32'h0000_000C;
         dmem_ack       = (c == 1) || (c == 4);
         dmem_rdata     = (c < 3) ? 32'hAAAA_0001 : 32'hBBBB_0002;
         #2;
         checks++; if (MEM_stall !== exp_stall[c]) $display("FAIL b2b_stall cycle %0d got %b want %b", c, MEM_stall, exp_stall[c]); else passed++;
         checks++; if (dmem_req !== exp_req[c]) $display("FAIL b2b_req cycle %0d got %b want %b", c, dmem_req, exp_req[c]); else passed++;
         if (c == 1) begin
            checks++; if (dmem_addr !== 30'h2) $display("FAIL b2b_addr1 got %h want 2", dmem_addr); else passed++;
         end
         if (c == 4) begin
            checks++; if (dmem_addr !== 30'h3) $display("FAIL b2b_addr2 got %h want 3", dmem_addr); else passed++;
         end
         if (c == 2) begin
            checks++; if (MEM_dm_read_data !== 32'hAAAA_0001) $display("FAIL b2b_data1 got %h want aaaa0001", MEM_dm_read_data); else passed++;
         end
         if (c == 5) begin
            checks++; if (MEM_dm_read_data !== 32'hBBBB_0002) $display("FAIL b2b_data2 got %h want bbbb0002", MEM_dm_read_data); else passed++;
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_in_access();
      MEM_valid          = 1'b1;
      MEM_dm_read_enable = 1'b1;
      MEM_alu_result     = 32'h0000_0040;
      tick();
      #2;
      checks++; if (dmem_req !== 1'b1) $display("FAIL rst_access1_req got %b want 1", dmem_req); else passed++;
      tick();
      reset = 1'b1;
      #2;
      checks++; if (dmem_req !== 1'b1) $display("FAIL rst_access2_req got %b want 1", dmem_req); else passed++;
      tick();
      reset      = 1'b0;
      MEM_valid  = 1'b0;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h7777_7777;
      #2;
      checks++; if (dmem_req !== 1'b0) $display("FAIL rst_req got %b want 0", dmem_req); else passed++;
      checks++; if (dmem_addr !== 30'h0) $display("FAIL rst_addr got %h want 0", dmem_addr); else passed++;
      checks++; if (dmem_we !== 1'b0) $display("FAIL rst_we got %b want 0", dmem_we); else passed++;
      checks++; if (dmem_wdata !== 32'h0) $display("FAIL rst_wdata got %h want 0", dmem_wdata); else passed++;
      checks++; if (MEM_dm_read_data !== 32'h0) $display("FAIL rst_data got %h want 0", MEM_dm_read_data); else passed++;
      checks++; if (MEM_stall !== 1'b0) $display("FAIL rst_stall got %b want 0", MEM_stall); else passed++;
      tick();
      #2;
      checks++; if (dmem_req !== 1'b0) $display("FAIL rst_late_ack_req got %b want 0", dmem_req); else passed++;
      checks++; if (MEM_dm_read_data !== 32'h0) $display("FAIL rst_late_ack_data got %h want 0", MEM_dm_read_data); else passed++;
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_timeout();
      MEM_valid          = 1'b1;
      MEM_dm_read_enable = 1'b1;
      MEM_alu_result     = 32'h0000_0050;
      tick();
`ifdef DM_TIMEOUT_EN
      for (int k = 1; k <= 15; k++) begin
         #2;
         checks++; if (dmem_req !== 1'b1 || MEM_bus_error !== 1'b0) $display("FAIL timeout_wait cycle %0d req %b err %b want 1 0", k, dmem_req, MEM_bus_error); else passed++;
         tick();
      end
      #2;
      checks++; if (MEM_bus_error !== 1'b1) $display("FAIL timeout_bus_error got %b want 1", MEM_bus_error); else passed++;
      checks++; if (dmem_req !== 1'b0) $display("FAIL timeout_req got %b want 0", dmem_req); else passed++;
      checks++; if (MEM_stall !== 1'b0) $display("FAIL timeout_stall got %b want 0", MEM_stall); else passed++;
      checks++; if (MEM_dm_read_data !== 32'hDEAD_BEEF) $display("FAIL timeout_data got %h want deadbeef", MEM_dm_read_data); else passed++;
      tick();
      idle_inputs();
      #2;
      checks++; if (MEM_bus_error !== 1'b0) $display("FAIL timeout_pulse_end got %b want 0", MEM_bus_error); else passed++;
      checks++; if (MEM_stall !== 1'b0) $display("FAIL timeout_idle_stall got %b want 0", MEM_stall); else passed++;
`else
      for (int k = 1; k <= 20; k++) begin
         #2;
         checks++; if (dmem_req !== 1'b1 || MEM_stall !== 1'b1 || MEM_bus_error !== 1'b0) $display("FAIL nowait_cycle %0d req %b stall %b err %b want 1 1 0", k, dmem_req, MEM_stall, MEM_bus_error); else passed++;
         tick();
      end
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h0000_0055;
      tick();
      dmem_ack = 1'b0;
      #2;
      checks++; if (MEM_dm_read_data !== 32'h0000_0055) $display("FAIL nowait_data got %h want 00000055", MEM_dm_read_data); else passed++;
      checks++; if (MEM_stall !== 1'b0) $display("FAIL nowait_done_stall got %b want 0", MEM_stall); else passed++;
      tick();
      idle_inputs();
`endif
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_load();
      test_store();
      test_misaligned();
      test_back_to_back();
      test_reset_in_access();
      test_timeout();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
